// File: rtl/vit_pkg.sv
// vit_pkg -- shared definitions for the Viterbi survivor-path slice.
//   vit_ns(k)     : number of trellis states for constraint length k (2^(k-1))
//   vit_log2(n)   : ceiling log2, used to size indices and counters
//   vit_state_e   : survivor unit control state (RUN accepts symbols, FLUSH drains)
package vit_pkg;

  function automatic int vit_ns(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int vit_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } vit_state_e;

endpackage

// File: rtl/vit_min_select.sv
// vit_min_select -- combinational argmin over NS path metrics.
// Ports:
//   pm_i   : NS packed unsigned metrics, state s at [s*PM_WIDTH +: PM_WIDTH]
//   best_o : index of the smallest metric; equal metrics resolve to the lowest index
// Built as a binary tree in heap layout: leaf NS+s holds state s, node n compares
// children 2n (lower indices) and 2n+1. The left child wins ties, which keeps the
// lowest-index rule at every level.
module vit_min_select
  import vit_pkg::*;
#(
  parameter int NS       = 4,
  parameter int PM_WIDTH = 8,
  parameter int IW       = vit_log2(NS)
) (
  input  logic [NS*PM_WIDTH-1:0] pm_i,
  output logic [IW-1:0]          best_o
);

  logic [PM_WIDTH-1:0] node_pm  [2*NS];
  logic [IW-1:0]       node_idx [2*NS];

  always_comb begin
    for (int n = 0; n < 2*NS; n++) begin
      node_pm[n]  = '0;
      node_idx[n] = '0;
    end
    for (int s = 0; s < NS; s++) begin
      node_pm[NS+s]  = pm_i[s*PM_WIDTH +: PM_WIDTH];
      node_idx[NS+s] = IW'(s);
    end
    for (int n = NS - 1; n >= 1; n--) begin
      if (node_pm[2*n+1] < node_pm[2*n]) begin
        node_pm[n]  = node_pm[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end else begin
        node_pm[n]  = node_pm[2*n];
        node_idx[n] = node_idx[2*n];
      end
    end
    best_o = node_idx[1];
  end

endmodule

// File: rtl/survivor_path_unit.sv
// survivor_path_unit -- register-exchange survivor memory with frame flush.
// Ports:
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   valid_i/ready_o: symbol handshake; ready_o is low while a frame is flushed
//   dec_bits_i     : ACS decision per next-state (bit s)
//   pm_i           : packed path metrics, state s at [s*PM_WIDTH +: PM_WIDTH]
//   frame_end_i    : accepted symbol is the last of its frame
//   term_mode_i    : 1 = zero-tailed frame, flush from state 0
//   data_o/valid_o : decoded bit and its single-cycle qualifier
//   last_o         : final decoded bit of the frame
//   best_state_o   : argmin state of the last accepted symbol
module survivor_path_unit
  import vit_pkg::*;
#(
  parameter int K        = 3,
  parameter int TBL      = 15,
  parameter int PM_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [vit_ns(K)-1:0]           dec_bits_i,
  input  logic [vit_ns(K)*PM_WIDTH-1:0]  pm_i,
  input  logic                           frame_end_i,
  input  logic                           term_mode_i,
  output logic                           data_o,
  output logic                           valid_o,
  output logic                           last_o,
  output logic [K-2:0]                   best_state_o
);

  localparam int NS = vit_ns(K);
  localparam int SW = K - 1;
  localparam int CW = vit_log2(TBL + 1);

  logic [TBL-1:0] path_q   [NS];
  logic [TBL-1:0] new_path [NS];
  logic [SW-1:0]  best;
  logic [SW-1:0]  fs_q;
  logic [CW-1:0]  c_q;
  logic [CW-1:0]  c_upd;
  logic [CW-1:0]  f_cnt;
  logic [CW-1:0]  idx_q;
  logic           emit_run;
  logic           accept;
  vit_state_e     state_q;

  vit_min_select #(
    .NS       (NS),
    .PM_WIDTH (PM_WIDTH),
    .IW       (SW)
  ) u_min (
    .pm_i   (pm_i),
    .best_o (best)
  );

  // Predecessor of state s is {dec[s], s[SW-1:1]}: the decision bit picks which
  // of the two states feeding s survives; s[0] is the bit that entered the coder.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      logic [SW-1:0] sb;
      logic [SW-1:0] p;
      sb = SW'(s);
      p  = {dec_bits_i[s], sb[SW-1:1]};
      new_path[s] = {path_q[p][TBL-2:0], sb[0]};
    end
  end

  assign accept   = valid_i && ready_o && (state_q == ST_RUN);
  assign c_upd    = (c_q == CW'(TBL)) ? c_q : c_q + CW'(1);
  assign emit_run = (c_upd == CW'(TBL));
  // The RUN bit already took position TBL-1, so at most TBL-1 bits remain.
  assign f_cnt    = (c_upd > CW'(TBL - 1)) ? CW'(TBL - 1) : c_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) path_q[s] <= '0;
      c_q          <= '0;
      fs_q         <= '0;
      idx_q        <= '0;
      state_q      <= ST_RUN;
      ready_o      <= 1'b1;
      data_o       <= 1'b0;
      valid_o      <= 1'b0;
      last_o       <= 1'b0;
      best_state_o <= '0;
    end else begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            best_state_o <= best;
            for (int s = 0; s < NS; s++) path_q[s] <= new_path[s];
            if (emit_run) begin
              data_o  <= new_path[best][TBL-1];
              valid_o <= 1'b1;
            end
            if (frame_end_i) begin
              c_q     <= '0;
              fs_q    <= term_mode_i ? '0 : best;
              idx_q   <= f_cnt - CW'(1);
              state_q <= ST_FLUSH;
              ready_o <= 1'b0;
            end else begin
              c_q <= c_upd;
            end
          end
        end
        ST_FLUSH: begin
          data_o  <= path_q[fs_q][idx_q];
          valid_o <= 1'b1;
          if (idx_q == '0) begin
            // Final bit: start the next frame from a clean survivor memory.
            last_o <= 1'b1;
            for (int s = 0; s < NS; s++) path_q[s] <= '0;
            c_q     <= '0;
            state_q <= ST_RUN;
            ready_o <= 1'b1;
          end else begin
            idx_q <= idx_q - CW'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule
